// File: rtl/i2c_sensor_poller.sv
// i2c_sensor_poller: periodically reads an N-byte sensor register over the byte-FIFO I2C master and raises interrupts on new values
module i2c_sensor_poller #(
  parameter int          NumBytes     = 2,
  parameter logic [6:0]  I2CAddr      = 7'h48,
  parameter logic [7:0]  RegAddr      = 8'h00,
  parameter int          CounterWidth = 16,
  localparam int         DataWidth    = 8 * NumBytes
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic                    Enable_i,
  input  logic                    ThresholdMode_i,
  input  logic [CounterWidth-1:0] PeriodCounterPreset_i,
  input  logic [CounterWidth-1:0] WaitCounterPreset_i,
  input  logic [DataWidth-1:0]    Threshold_i,
  output logic [DataWidth-1:0]    SensorValue_o,
  output logic                    Valid_o,
  output logic                    CpuIntr_o,
  output logic                    ErrorIntr_o,
  output logic                    I2C_ReceiveSend_n_o,
  output logic [7:0]              I2C_ReadCount_o,
  output logic                    I2C_StartProcess_o,
  input  logic                    I2C_Busy_i,
  output logic                    I2C_FIFOWrite_o,
  output logic [7:0]              I2C_Data_o,
  output logic                    I2C_FIFOReadNext_o,
  input  logic [7:0]              I2C_Data_i,
  input  logic                    I2C_Error_i
);
  typedef enum logic [3:0] {
    S_DIS, S_IDLE, S_WR_ADDR, S_WR_REG, S_WR_START, S_WAIT_PTR, S_CONV,
    S_RD_ADDR, S_RD_START, S_WAIT_RD, S_FETCH, S_EVAL, S_ERR
  } state_e;
  state_e                  state_q, state_d;
  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0]    val_q, val_d, shift_q, shift_d, diff;
  logic                    valid_q, valid_d, cpu_q, cpu_d, seen_q, seen_d, rsn_q, rsn_d, upd, act;
  logic [7:0]              rc_q, rc_d;
  assign diff = shift_q > val_q ? shift_q - val_q : val_q - shift_q;
  assign upd  = ThresholdMode_i ? shift_q > Threshold_i : (!valid_q || diff > Threshold_i);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    valid_d = valid_q;
    shift_d = shift_q;
    rsn_d   = rsn_q;
    rc_d    = rc_q;
    cpu_d   = 1'b0;
    seen_d  = 1'b0;
    case (state_q)
      S_DIS: if (Enable_i) begin
        state_d = S_IDLE;
        cnt_d   = PeriodCounterPreset_i;
      end
      S_IDLE: if (!Enable_i) begin
        state_d = S_DIS;
        valid_d = 1'b0;
      end else if (cnt_q == '0) begin
        state_d = S_WR_ADDR;
        rsn_d   = 1'b0;
        rc_d    = 8'd0;
      end else cnt_d = cnt_q - 1'b1;
      S_WR_ADDR:  state_d = S_WR_REG;
      S_WR_REG:   state_d = S_WR_START;
      S_WR_START: state_d = S_WAIT_PTR;
      // Busy only rises the cycle after StartProcess, so the first wait cycle is ignored
      S_WAIT_PTR, S_WAIT_RD: begin
        seen_d = 1'b1;
        if (seen_q && !I2C_Busy_i) begin
          state_d = I2C_Error_i ? S_ERR : (state_q == S_WAIT_PTR ? S_CONV : S_FETCH);
          cnt_d   = state_q == S_WAIT_PTR ? WaitCounterPreset_i : CounterWidth'(NumBytes - 1);
        end
      end
      S_CONV: if (cnt_q == '0) state_d = S_RD_ADDR;
              else cnt_d = cnt_q - 1'b1;
      S_RD_ADDR: begin
        state_d = S_RD_START;
        rsn_d   = 1'b1;
        rc_d    = 8'(NumBytes);
      end
      S_RD_START: state_d = S_WAIT_RD;
      S_FETCH: begin
        shift_d = DataWidth'({shift_q, I2C_Data_i});
        if (cnt_q == '0) state_d = S_EVAL;
        else cnt_d = cnt_q - 1'b1;
      end
      S_EVAL: begin
        if (upd) begin
          val_d   = shift_q;
          valid_d = 1'b1;
          cpu_d   = 1'b1;
        end
        if (Enable_i) begin
          state_d = S_IDLE;
          cnt_d   = PeriodCounterPreset_i;
        end else begin
          state_d = S_DIS;
          valid_d = 1'b0;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
        cnt_d   = PeriodCounterPreset_i;
      end
      default: state_d = S_DIS;
    endcase
  end
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q <= S_DIS;
      cnt_q   <= '0;
      val_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      cpu_q   <= 1'b0;
      seen_q  <= 1'b0;
      rsn_q   <= 1'b0;
      rc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      cpu_q   <= cpu_d;
      seen_q  <= seen_d;
      rsn_q   <= rsn_d;
      rc_q    <= rc_d;
    end
  end
  // Strobes are decoded from state, so they are masked while reset is being applied
  assign act                 = !Reset_i;
  assign SensorValue_o       = val_q;
  assign Valid_o             = valid_q;
  assign CpuIntr_o           = act && cpu_q;
  assign ErrorIntr_o         = act && state_q == S_ERR;
  assign I2C_ReceiveSend_n_o = rsn_q;
  assign I2C_ReadCount_o     = rc_q;
  assign I2C_StartProcess_o  = act && (state_q == S_WR_START || state_q == S_RD_START);
  assign I2C_FIFOWrite_o     = act && (state_q == S_WR_ADDR || state_q == S_WR_REG || state_q == S_RD_ADDR);
  assign I2C_FIFOReadNext_o  = act && state_q == S_FETCH;
  assign I2C_Data_o          = state_q == S_WR_ADDR ? {I2CAddr, 1'b0} :
                               state_q == S_WR_REG  ? RegAddr :
                               state_q == S_RD_ADDR ? {I2CAddr, 1'b1} : 8'd0;
endmodule

// File: tb/tb_i2c_sensor_poller.sv
// tb_i2c_sensor_poller: directed bench with a small I2C core model shared by a 2-byte and a 3-byte poller
module tb_i2c_sensor_poller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, en2, en3, mode, err_en;
  logic [15:0] per, wt, thr2, sv2;
  logic [23:0] thr3, sv3;
  logic        busy, err;
  logic [7:0]  di, rc2, rc3, d2, d3;
  logic        v2, v3, cpu2, cpu3, e2, e3, rsn2, rsn3, sp2, sp3, fw2, fw3, rn2, rn3;
  logic        sp, fw, rn, rsn;
  logic [7:0]  d;
  logic [2:0]  bcnt = 3'd0;
  logic        err_q = 1'b0;
  logic [1:0]  rp = 2'd0;
  logic [7:0]  rx [4];
  logic [7:0]  txq [$];
  int cyc = 0, n_ps = 0, n_rs = 0, n_rn = 0, n_cpu = 0, n_err = 0;
  int ps_cyc = 0, rs_cyc = 0, wr_cyc = 0, cpu_cyc = 0;
  int vec = 0, miss = 0;
  int c0, e0, r0, pc, t0;

  i2c_sensor_poller #(.NumBytes(2)) u2 (
    .Clk_i(clk), .Reset_i(rst), .Enable_i(en2), .ThresholdMode_i(mode),
    .PeriodCounterPreset_i(per), .WaitCounterPreset_i(wt), .Threshold_i(thr2),
    .SensorValue_o(sv2), .Valid_o(v2), .CpuIntr_o(cpu2), .ErrorIntr_o(e2),
    .I2C_ReceiveSend_n_o(rsn2), .I2C_ReadCount_o(rc2), .I2C_StartProcess_o(sp2),
    .I2C_Busy_i(busy), .I2C_FIFOWrite_o(fw2), .I2C_Data_o(d2),
    .I2C_FIFOReadNext_o(rn2), .I2C_Data_i(di), .I2C_Error_i(err));

  i2c_sensor_poller #(.NumBytes(3)) u3 (
    .Clk_i(clk), .Reset_i(rst), .Enable_i(en3), .ThresholdMode_i(mode),
    .PeriodCounterPreset_i(per), .WaitCounterPreset_i(wt), .Threshold_i(thr3),
    .SensorValue_o(sv3), .Valid_o(v3), .CpuIntr_o(cpu3), .ErrorIntr_o(e3),
    .I2C_ReceiveSend_n_o(rsn3), .I2C_ReadCount_o(rc3), .I2C_StartProcess_o(sp3),
    .I2C_Busy_i(busy), .I2C_FIFOWrite_o(fw3), .I2C_Data_o(d3),
    .I2C_FIFOReadNext_o(rn3), .I2C_Data_i(di), .I2C_Error_i(err));

  // Only one poller is enabled at a time, so the core sees the OR of both
  assign sp   = sp2 | sp3;
  assign fw   = fw2 | fw3;
  assign rn   = rn2 | rn3;
  assign d    = fw2 ? d2 : d3;
  assign rsn  = sp2 ? rsn2 : rsn3;
  assign busy = bcnt != 3'd0;
  assign err  = err_q && !busy;
  assign di   = rx[rp];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sp) begin
      bcnt  <= 3'd4;
      rp    <= 2'd0;
      err_q <= rsn && err_en;
    end else if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
    if (rn) begin
      rp   <= rp + 2'd1;
      n_rn <= n_rn + 1;
    end
    if (fw) begin
      txq.push_back(d);
      if (d == 8'h90) wr_cyc <= cyc;
    end
    if (sp && !rsn) begin ps_cyc <= cyc; n_ps <= n_ps + 1; end
    if (sp && rsn)  begin rs_cyc <= cyc; n_rs <= n_rs + 1; end
    if (cpu2 | cpu3) begin cpu_cyc <= cyc; n_cpu <= n_cpu + 1; end
    if (e2 | e3) n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rs();
    int s = n_rs;
    for (int i = 0; i < 300 && n_rs == s; i++) @(negedge clk);
    chk("rd_start_seen", 32'(n_rs != s), 32'd1);
  endtask

  task automatic wait_ps();
    int s = n_ps;
    for (int i = 0; i < 300 && n_ps == s; i++) @(negedge clk);
    chk("ptr_start_seen", 32'(n_ps != s), 32'd1);
  endtask

  task automatic sample(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    rx[0] = b0; rx[1] = b1; rx[2] = b2;
    wait_rs();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en2 = 1'b0; en3 = 1'b0; mode = 1'b0; err_en = 1'b0;
    per = 16'd9; wt = 16'd3; thr2 = 16'h0010; thr3 = 24'h0;
    for (int i = 0; i < 4; i++) rx[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_value", sv2, 32'h0);
    chk("rst_valid_rc_rsn", {v2, rsn2, rc2}, 32'h0);
    chk("rst_strobes_data", {cpu2, e2, sp2, fw2, rn2, d2}, 32'h0);
    rst = 1'b0;
    en2 = 1'b1;
    c0 = n_cpu;
    sample(8'h0C, 8'h80, 8'h00);
    chk("tx_count", txq.size(), 32'd3);
    chk("tx_wr_addr", txq[0], 32'h90);
    chk("tx_reg_addr", txq[1], 32'h00);
    chk("tx_rd_addr", txq[2], 32'h91);
    chk("wr_to_start", ps_cyc - wr_cyc, 32'd2);
    chk("ptr_to_rd_start", rs_cyc - ps_cyc, 32'd11);
    chk("read_count", rc2, 32'd2);
    chk("recv_send_n", rsn2, 32'd1);
    chk("basic_value", sv2, 32'h0C80);
    chk("basic_valid", v2, 32'd1);
    chk("basic_intr", n_cpu - c0, 32'd1);
    pc = cpu_cyc;
    c0 = n_cpu;
    sample(8'h0C, 8'h90, 8'h00);
    chk("period", wr_cyc - pc, 32'd10);
    chk("m0_up_eq_value", sv2, 32'h0C80);
    chk("m0_up_eq_intr", n_cpu - c0, 32'd0);
    sample(8'h0C, 8'h70, 8'h00);
    chk("m0_dn_eq_value", sv2, 32'h0C80);
    chk("m0_dn_eq_intr", n_cpu - c0, 32'd0);
    sample(8'h0C, 8'h6F, 8'h00);
    chk("m0_dn_gt_value", sv2, 32'h0C6F);
    chk("m0_dn_gt_intr", n_cpu - c0, 32'd1);
    mode = 1'b1; thr2 = 16'h1000;
    c0 = n_cpu;
    sample(8'h0F, 8'hFF, 8'h00);
    chk("m1_below_value", sv2, 32'h0C6F);
    chk("m1_below_intr", n_cpu - c0, 32'd0);
    sample(8'h10, 8'h01, 8'h00);
    chk("m1_above_value", sv2, 32'h1001);
    chk("m1_above_intr", n_cpu - c0, 32'd1);
    sample(8'h10, 8'h00, 8'h00);
    chk("m1_equal_value", sv2, 32'h1001);
    chk("m1_equal_intr", n_cpu - c0, 32'd1);
    err_en = 1'b1;
    e0 = n_err; r0 = n_rn;
    sample(8'hAA, 8'hAA, 8'h00);
    chk("err_pulse", n_err - e0, 32'd1);
    chk("err_no_fetch", n_rn - r0, 32'd0);
    chk("err_value", sv2, 32'h1001);
    chk("err_valid", v2, 32'd1);
    chk("err_no_intr", n_cpu - c0, 32'd1);
    err_en = 1'b0;
    sample(8'h20, 8'h00, 8'h00);
    chk("resume_value", sv2, 32'h2000);
    chk("resume_intr", n_cpu - c0, 32'd2);
    chk("resume_no_err", n_err - e0, 32'd1);
    rx[0] = 8'h30; rx[1] = 8'h00;
    wait_ps();
    repeat (6) @(negedge clk);
    en2 = 1'b0;
    wait_rs();
    repeat (12) @(negedge clk);
    chk("dis_value", sv2, 32'h3000);
    chk("dis_valid", v2, 32'd0);
    chk("dis_intr", n_cpu - c0, 32'd3);
    t0 = txq.size();
    repeat (40) @(negedge clk);
    chk("dis_no_poll", txq.size() - t0, 32'd0);
    en2 = 1'b1;
    rx[0] = 8'h55; rx[1] = 8'h66;
    wait_rs();
    repeat (5) @(negedge clk);
    chk("fetch_active", rn2, 32'd1);
    r0 = n_rn;
    rst = 1'b1; en2 = 1'b0;
    @(negedge clk);
    chk("midrst_value", sv2, 32'h0);
    chk("midrst_valid_rc_rsn", {v2, rsn2, rc2}, 32'h0);
    chk("midrst_strobes", {cpu2, e2, sp2, fw2, rn2, d2}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_fetch", n_rn - r0, 32'd0);
    mode = 1'b0; en3 = 1'b1;
    c0 = n_cpu; r0 = n_rn;
    txq.delete();
    sample(8'h01, 8'h02, 8'h03);
    chk("nb3_read_count", rc3, 32'd3);
    chk("nb3_fetches", n_rn - r0, 32'd3);
    chk("nb3_value", sv3, 32'h010203);
    chk("nb3_valid", v3, 32'd1);
    chk("nb3_tx_rd_addr", txq[2], 32'h91);
    chk("nb3_intr", n_cpu - c0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
